// File: rtl/bus_ser_q.sv
// bus_ser_q: queues block-side requests and serialises each one onto a shared
// tri-state bus as one or more data beats, after a req/ack/grant handshake
// with the bus arbiter.
module bus_ser_q #(
    parameter int DATA_W = 128,
    parameter int BEAT_W = 32,
    parameter int DEPTH  = 2,
    localparam int NBEATS = DATA_W / BEAT_W,
    localparam int BPB    = BEAT_W / 8,
    localparam int BUS_W  = BEAT_W + 41
) (
    input  logic              clk_bus,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [14:0]       pAdr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        return_in,
    input  logic              rw_in,
    input  logic [15:0]       size_in,
    output logic              full_block,
    output logic              free_block,
    input  logic              ack,
    input  logic              grant,
    output logic              req,
    output logic              releases,
    output logic [3:0]        dest_bau,
    inout  wire  [BUS_W-1:0]  BUS
);

    localparam int BC_W  = $clog2(NBEATS + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAITG, S_SEND} state_t;

    state_t            state, state_nxt;
    logic [BC_W-1:0]   beat_cnt;
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;

    logic [14:0]       padr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [3:0]        dest_q [DEPTH];
    logic [3:0]        ret_q  [DEPTH];
    logic              rw_q   [DEPTH];
    logic [15:0]       size_q [DEPTH];

    logic              enq, deq, last_beat, bus_en;
    logic [BC_W-1:0]   head_nb;
    logic [BEAT_W-1:0] beat_data;
    logic [BUS_W-1:0]  bus_val;

    // Writes: ceil(size/BPB), zero size still moves one beat, saturate at NBEATS.
    // Reads always move a single beat.
    function automatic logic [BC_W-1:0] beats_for(input logic is_wr, input logic [15:0] sz);
        logic [16:0] n;
        if (!is_wr)
            return BC_W'(1);
        n = ({1'b0, sz} + 17'(BPB - 1)) / 17'(BPB);
        if (n == 17'd0)
            return BC_W'(1);
        if (n > 17'(NBEATS))
            return BC_W'(NBEATS);
        return BC_W'(n);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_block = (count == CNT_W'(DEPTH));
    assign free_block = (count == '0) && (state == S_IDLE);
    assign dest_bau   = (count != '0) ? dest_q[head] : 4'd0;
    assign enq        = valid_in && !full_block;
    assign head_nb    = beats_for(rw_q[head], size_q[head]);
    assign last_beat  = (beat_cnt == head_nb - BC_W'(1));
    assign deq        = (state == S_SEND) && last_beat;

    // Queue bookkeeping: pointers and occupancy; enqueue and dequeue may coincide.
    always_ff @(posedge clk_bus or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)
                tail <= ptr_inc(tail);
            if (deq)
                head <= ptr_inc(head);
            if (enq && !deq)
                count <= count + CNT_W'(1);
            else if (deq && !enq)
                count <= count - CNT_W'(1);
        end
    end

    // Entry payload capture; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk_bus) begin
        if (enq) begin
            padr_q[tail] <= pAdr_in;
            data_q[tail] <= data_in;
            dest_q[tail] <= dest_in;
            ret_q[tail]  <= return_in;
            rw_q[tail]   <= rw_in;
            size_q[tail] <= size_in;
        end
    end

    // FSM state register and beat counter (cleared when SEND is entered).
    always_ff @(posedge clk_bus or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WAITG && grant)
                beat_cnt <= '0;
            else if (state == S_SEND && !last_beat)
                beat_cnt <= beat_cnt + BC_W'(1);
        end
    end

    // Next-state logic plus req / releases / bus-drive decode.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        releases  = 1'b0;
        bus_en    = 1'b0;
        case (state)
            S_IDLE:  if (count != '0) state_nxt = S_REQ;
            S_REQ: begin
                req = 1'b1;
                if (ack) state_nxt = S_WAITG;
            end
            S_WAITG: if (grant) state_nxt = S_SEND;
            S_SEND: begin
                bus_en = 1'b1;
                if (last_beat) begin
                    releases  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Current beat of the head payload; reads carry a zero data field.
    always_comb begin
        beat_data = '0;
        for (int k = 0; k < NBEATS; k++)
            if (beat_cnt == BC_W'(k))
                beat_data = data_q[head][k*BEAT_W +: BEAT_W];
        if (!rw_q[head])
            beat_data = '0;
    end

    assign bus_val = {size_q[head], rw_q[head], dest_q[head], ret_q[head],
                      beat_data, padr_q[head], 1'b1};
    assign BUS     = bus_en ? bus_val : {BUS_W{1'bz}};

endmodule

// File: tb/tb_bus_ser_q.sv
// tb_bus_ser_q: directed bench for bus_ser_q with default parameters.
module tb_bus_ser_q;

    localparam int BUS_W = 73;
    localparam logic [BUS_W-1:0] BUS_IDLE = {BUS_W{1'b1}};

    logic         clk_bus;
    logic         rst;
    logic         valid_in;
    logic [14:0]  pAdr_in;
    logic [127:0] data_in;
    logic [3:0]   dest_in;
    logic [3:0]   return_in;
    logic         rw_in;
    logic [15:0]  size_in;
    logic         full_block;
    logic         free_block;
    logic         ack;
    logic         grant;
    logic         req;
    logic         releases;
    logic [3:0]   dest_bau;
    tri1 [BUS_W-1:0] bus_w;

    int errors = 0;
    int checks = 0;

    bus_ser_q #(.DATA_W(128), .BEAT_W(32), .DEPTH(2)) dut (
        .clk_bus(clk_bus), .rst(rst), .valid_in(valid_in), .pAdr_in(pAdr_in),
        .data_in(data_in), .dest_in(dest_in), .return_in(return_in), .rw_in(rw_in),
        .size_in(size_in), .full_block(full_block), .free_block(free_block),
        .ack(ack), .grant(grant), .req(req), .releases(releases),
        .dest_bau(dest_bau), .BUS(bus_w)
    );

    initial clk_bus = 1'b0;
    always #5 clk_bus = ~clk_bus;

    task automatic tick();
        @(posedge clk_bus);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] exp_bus(input logic [14:0] pa, input logic [31:0] d,
                                                 input logic [3:0] rt, input logic [3:0] ds,
                                                 input logic rw, input logic [15:0] sz);
        logic [BUS_W-1:0] b;
        b        = '0;
        b[0]     = 1'b1;
        b[15:1]  = pa;
        b[47:16] = d;
        b[51:48] = rt;
        b[55:52] = ds;
        b[56]    = rw;
        b[72:57] = sz;
        return b;
    endfunction

    task automatic set_in(input logic [14:0] pa, input logic [127:0] d, input logic [3:0] ds,
                          input logic [3:0] rt, input logic rw, input logic [15:0] sz);
        pAdr_in = pa; data_in = d; dest_in = ds; return_in = rt; rw_in = rw; size_in = sz;
    endtask

    task automatic enq(input logic [14:0] pa, input logic [127:0] d, input logic [3:0] ds,
                       input logic [3:0] rt, input logic rw, input logic [15:0] sz);
        set_in(pa, d, ds, rt, rw, sz);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    // Starts with the FSM in REQ; ends just after the edge closing the last beat.
    task automatic xfer_from_req(input logic [14:0] pa, input logic [127:0] d, input logic [3:0] ds,
                                 input logic [3:0] rt, input logic rw, input logic [15:0] sz,
                                 input int nb);
        logic [31:0] w;
        chk("req_in_req", 128'(req), 128'(1));
        chk("dest_bau_head", 128'(dest_bau), 128'(ds));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("req_in_waitg", 128'(req), 128'(0));
        chk("bus_z_waitg", 128'(bus_w), 128'(BUS_IDLE));
        grant = 1'b1;
        tick();
        grant = 1'b0;
        for (int b = 0; b < nb; b++) begin
            w = rw ? d[b*32 +: 32] : 32'h0;
            chk($sformatf("bus_beat%0d", b), 128'(bus_w), 128'(exp_bus(pa, w, rt, ds, rw, sz)));
            chk($sformatf("releases_beat%0d", b), 128'(releases), 128'(b == nb - 1));
            tick();
        end
        chk("bus_z_after", 128'(bus_w), 128'(BUS_IDLE));
        chk("releases_after", 128'(releases), 128'(0));
    endtask

    localparam logic [127:0] D0 = 128'hD3D3_0003_D2D2_0002_D1D1_0001_D0D0_0000;
    localparam logic [127:0] D1 = 128'h5555_AAAA_6666_BBBB_7777_CCCC_8888_DDDD;

    initial begin
        logic [15:0] sz_tab [3];
        int          nb_tab [3];
        sz_tab = '{16'd0, 16'd5, 16'd200};
        nb_tab = '{1, 2, 4};

        rst = 1'b0; valid_in = 1'b0; ack = 1'b0; grant = 1'b0;
        set_in(15'h0, 128'h0, 4'h0, 4'h0, 1'b0, 16'h0);
        tick();
        tick();
        chk("rst_full", 128'(full_block), 128'(0));
        chk("rst_free", 128'(free_block), 128'(1));
        chk("rst_req", 128'(req), 128'(0));
        chk("rst_releases", 128'(releases), 128'(0));
        chk("rst_dest_bau", 128'(dest_bau), 128'(0));
        chk("rst_bus_z", 128'(bus_w), 128'(BUS_IDLE));
        rst = 1'b1;

        // Four-beat write, size 16
        enq(15'h1234, D0, 4'h5, 4'hA, 1'b1, 16'd16);
        chk("w16_free", 128'(free_block), 128'(0));
        chk("w16_req_idle", 128'(req), 128'(0));
        chk("w16_dest_bau", 128'(dest_bau), 128'(5));
        tick();
        xfer_from_req(15'h1234, D0, 4'h5, 4'hA, 1'b1, 16'd16, 4);
        chk("w16_free_after1", 128'(free_block), 128'(1));
        tick();
        chk("w16_free_after2", 128'(free_block), 128'(1));
        chk("w16_req_stays0", 128'(req), 128'(0));

        // Single-beat read, size 64, data field zero
        enq(15'h0042, D1, 4'h3, 4'h7, 1'b0, 16'd64);
        tick();
        xfer_from_req(15'h0042, D1, 4'h3, 4'h7, 1'b0, 16'd64, 1);

        // Write size handling: 0, 5, 200 bytes
        for (int i = 0; i < 3; i++) begin
            enq(15'h0100 + 15'(i), D1, 4'h9, 4'h2, 1'b1, sz_tab[i]);
            tick();
            xfer_from_req(15'h0100 + 15'(i), D1, 4'h9, 4'h2, 1'b1, sz_tab[i], nb_tab[i]);
        end

        // Early grant in REQ has no effect
        enq(15'h0777, D0, 4'hC, 4'h1, 1'b1, 16'd8);
        tick();
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("early_grant_req", 128'(req), 128'(1));
        chk("early_grant_bus_z", 128'(bus_w), 128'(BUS_IDLE));
        xfer_from_req(15'h0777, D0, 4'hC, 4'h1, 1'b1, 16'd8, 2);

        // Three back-to-back requests into a two-entry queue
        set_in(15'h0A0A, D0, 4'h1, 4'h4, 1'b1, 16'd4);
        valid_in = 1'b1;
        tick();
        chk("q_full_after1", 128'(full_block), 128'(0));
        set_in(15'h0B0B, D1, 4'h2, 4'h5, 1'b1, 16'd4);
        tick();
        chk("q_full_after2", 128'(full_block), 128'(1));
        set_in(15'h0C0C, D0, 4'h3, 4'h6, 1'b1, 16'd4);
        tick();
        valid_in = 1'b0;
        chk("q_full_after3", 128'(full_block), 128'(1));
        xfer_from_req(15'h0A0A, D0, 4'h1, 4'h4, 1'b1, 16'd4, 1);
        chk("q_gap_req", 128'(req), 128'(0));
        chk("q_dest_bau_b", 128'(dest_bau), 128'(2));
        chk("q_full_drained1", 128'(full_block), 128'(0));
        chk("q_free_not_empty", 128'(free_block), 128'(0));
        tick();
        xfer_from_req(15'h0B0B, D1, 4'h2, 4'h5, 1'b1, 16'd4, 1);
        chk("q_free_empty", 128'(free_block), 128'(1));
        tick();
        chk("q_third_dropped", 128'(req), 128'(0));

        // Reset during beat 2 of a four-beat write, with another entry queued
        enq(15'h0D0D, D0, 4'h8, 4'hB, 1'b1, 16'd16);
        enq(15'h0E0E, D1, 4'h9, 4'hC, 1'b1, 16'd4);
        chk("r_req", 128'(req), 128'(1));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        grant = 1'b1;
        tick();
        grant = 1'b0;
        tick();
        tick();
        chk("r_beat2", 128'(bus_w), 128'(exp_bus(15'h0D0D, 32'hD2D2_0002, 4'hB, 4'h8, 1'b1, 16'd16)));
        rst = 1'b0;
        #1;
        chk("r_bus_z", 128'(bus_w), 128'(BUS_IDLE));
        chk("r_req0", 128'(req), 128'(0));
        chk("r_releases0", 128'(releases), 128'(0));
        chk("r_free", 128'(free_block), 128'(1));
        chk("r_dest_bau", 128'(dest_bau), 128'(0));
        tick();
        rst = 1'b1;
        enq(15'h0F0F, D1, 4'h6, 4'hD, 1'b1, 16'd12);
        chk("r_first_enq_free", 128'(free_block), 128'(0));
        chk("r_first_enq_dest", 128'(dest_bau), 128'(6));
        chk("r_queue_discarded", 128'(full_block), 128'(0));
        tick();
        xfer_from_req(15'h0F0F, D1, 4'h6, 4'hD, 1'b1, 16'd12, 3);
        chk("r_final_free", 128'(free_block), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_ser_q.md
BUS_SER_Q -- requirements
Module: bus_ser_q

Interface
REQ-001 Parameter DATA_W, default 128, payload width in bits; SHALL be a multiple of BEAT_W.
REQ-002 Parameter BEAT_W, default 32, bus data beat width in bits; SHALL be a multiple of 8.
REQ-003 Parameter DEPTH, default 2, number of request-queue entries (>=1).
REQ-004 Derived values: NBEATS = DATA_W/BEAT_W, BPB = BEAT_W/8, BUS_W = BEAT_W+41.
REQ-005 Ports SHALL be:
- clk_bus  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_in  in  1  request present on the block-side inputs.
- pAdr_in  in  15  physical address.
- data_in  in  DATA_W  payload; beat k = data_in[k*BEAT_W +: BEAT_W].
- dest_in  in  4  destination unit ID.
- return_in  in  4  return unit ID.
- rw_in  in  1  1 = write, 0 = read request.
- size_in  in  16  transfer size in bytes.
- full_block  out  1  queue full; valid_in is ignored.
- free_block  out  1  queue empty and FSM in IDLE.
- ack  in  1  arbiter acknowledges req.
- grant  in  1  arbiter grants the bus.
- req  out  1  bus request to the arbiter.
- releases  out  1  last beat on the bus this cycle.
- dest_bau  out  4  dest of the queue head, to the arbiter.
- BUS  inout  BUS_W  fields: [0] valid, [15:1] pAdr, [BEAT_W+15:16] data, then return(4), dest(4), rw(1), size(16).

Function
REQ-006 Enqueue SHALL occur at an edge where valid_in=1 and full_block=0; the entry captures all block-side inputs.
REQ-007 full_block SHALL be 1 when the queue holds DEPTH entries.
REQ-008 An enqueue and a dequeue at the same edge SHALL both take effect.
REQ-009 full_block is evaluated before the edge, so a dequeue does not unblock an enqueue at that same edge.
REQ-010 Beat count for a write SHALL be ceil(size_in/BPB), with size_in=0 treated as 1 beat and values above NBEATS clamped to NBEATS.
REQ-011 A read (rw=0) SHALL always be 1 beat, with the BUS data field driven to 0.
REQ-012 The FSM SHALL have four states: IDLE, REQ, WAITG, SEND.
REQ-013 IDLE -> REQ on the first edge at which the queue is non-empty.
REQ-014 REQ -> WAITG on an edge with ack=1; grant is ignored in REQ.
REQ-015 WAITG -> SEND on an edge with grant=1; ack is ignored in WAITG.
REQ-016 SEND lasts exactly one cycle per beat, beats in ascending k.
REQ-017 On the edge ending the last beat, the FSM SHALL dequeue the head and return to IDLE, giving a one-cycle gap before the next REQ.
REQ-018 req SHALL be 1 exactly while in REQ.
REQ-019 dest_bau SHALL equal the head dest while the queue is non-empty, else 0.
REQ-020 BUS SHALL be driven only in SEND and SHALL be high-Z in all other states and during reset.
REQ-021 In SEND, BUS SHALL carry valid=1, the head pAdr/return/dest/rw, size = the entry's original size_in, and data = the current beat.
REQ-022 releases SHALL be 1 exactly during the last SEND cycle and is combinational from state and beat counter.
REQ-023 The beat counter SHALL be ceil(log2(NBEATS+1)) bits, cleared on entry to SEND.
REQ-024 Queue pointers SHALL wrap modulo DEPTH.

Reset
REQ-025 While rst=0: queue emptied, FSM=IDLE, beat counter=0, req=0, releases=0, full_block=0, free_block=1, dest_bau=0, BUS all Z.
REQ-026 Assertion of rst mid-transfer SHALL tri-state BUS immediately and discard all queued requests.
REQ-027 The first enqueue SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-028 Write, size 16, defaults: enqueue, ack the cycle after req, grant one cycle later -> four SEND beats carrying data words 0..3, releases only on beat 3, BUS Z afterwards, free_block=1 two cycles later.
REQ-029 Read, size 64: -> one beat with data field 0, size field 64, releases=1 in that cycle.
REQ-030 Sizes 0, 5, 200 on writes -> 1, 2 and 4 beats respectively.
REQ-031 DEPTH=2: three back-to-back valid_in pulses -> full_block=1 after the 2nd; the 3rd is dropped. Both accepted entries are sent in order with one IDLE cycle between them, and dest_bau follows the head.
REQ-032 grant asserted while in REQ before ack -> no transition; BUS stays Z until ack then grant.
REQ-033 rst pulled low during beat 2 -> BUS Z, req=0, releases=0 in the same cycle; after release, free_block=1 and the queue is empty.
